// File: rtl/count_monitor_pkg.sv
// Shared types and default widths for the counter step monitor.
package count_monitor_pkg;

  localparam int unsigned WIDTH_DEF      = 4;
  localparam int unsigned ERR_CNT_W_DEF  = 8;
  localparam int unsigned WRAP_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } cm_state_t;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating event counter; a clear and an increment in the same cycle yield 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  // Clear first, then count the new event, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Checks that each valid sample equals the previous one plus one (mod 2^WIDTH).
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ERR_CNT_W  = ERR_CNT_W_DEF,
  parameter int unsigned WRAP_CNT_W = WRAP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clr_err,
  output logic                  synced,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]      first_exp,
  output logic [WIDTH-1:0]      first_act
);

  localparam logic [WIDTH-1:0] MAX = '1;

  cm_state_t        state_q;
  cm_state_t        state_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] exp_c;
  logic             check_c;
  logic             mismatch_c;
  logic             wrap_c;
  logic             clr_c;
  logic             capture_c;

  // Sample classification against the held reference.
  always_comb begin
    check_c    = en && (state_q != IDLE);
    exp_c      = prev_q + WIDTH'(1);
    mismatch_c = check_c && (count_in != exp_c);
    wrap_c     = check_c && (prev_q == MAX) && (count_in == '0);
    clr_c      = clr_err && (state_q != IDLE);
    capture_c  = mismatch_c && (!err_sticky || clr_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear is applied before a same-cycle mismatch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = TRACK;
      TRACK:   if (mismatch_c) state_d = FAULT;
      FAULT: begin
        if (mismatch_c)  state_d = FAULT;
        else if (clr_c)  state_d = TRACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reference tracking, strobes, sticky flag and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      synced     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
      first_exp  <= '0;
      first_act  <= '0;
    end else begin
      err_pulse  <= mismatch_c;
      wrap_pulse <= wrap_c;
      if (en) prev_q <= count_in;
      if ((state_q == IDLE) && en) synced <= 1'b1;
      if (mismatch_c)  err_sticky <= 1'b1;
      else if (clr_c)  err_sticky <= 1'b0;
      if (capture_c) begin
        first_exp <= exp_c;
        first_act <= count_in;
      end else if (clr_c) begin
        first_exp <= '0;
        first_act <= '0;
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch_c),
    .clr   (clr_c),
    .count (err_count)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrap_c),
    .clr   (1'b0),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: vector table, directed sequences, random traffic.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] count_in;
  logic       clr_err;

  logic        synced, err_pulse, err_sticky, wrap_pulse;
  logic [7:0]  err_count;
  logic [15:0] wrap_count;
  logic [3:0]  first_exp, first_act;

  logic        synced2, err_pulse2, err_sticky2, wrap_pulse2;
  logic [1:0]  err_count2;
  logic [15:0] wrap_count2;
  logic [3:0]  first_exp2, first_act2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_monitor dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .synced(synced), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .first_exp(first_exp), .first_act(first_act)
  );

  count_monitor #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .synced(synced2), .err_pulse(err_pulse2), .err_sticky(err_sticky2),
    .err_count(err_count2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
    .first_exp(first_exp2), .first_act(first_act2)
  );

  // Behavioural reference: a held reference value plus integer tallies.
  bit m_synced, m_sticky, m_ep, m_wp;
  int m_prev, m_err, m_err2, m_wrap, m_fe, m_fa;

  task automatic model_step(input bit r, input bit e, input int c, input bit cl);
    int expv;
    if (r) begin
      m_synced = 0; m_sticky = 0; m_ep = 0; m_wp = 0;
      m_prev = 0; m_err = 0; m_err2 = 0; m_wrap = 0; m_fe = 0; m_fa = 0;
      return;
    end
    m_ep = 0; m_wp = 0;
    if (m_synced && cl) begin
      m_sticky = 0; m_err = 0; m_err2 = 0; m_fe = 0; m_fa = 0;
    end
    if (e) begin
      if (!m_synced) begin
        m_synced = 1;
      end else begin
        expv = (m_prev + 1) % 16;
        if (c != expv) begin
          m_ep = 1;
          if (!m_sticky) begin m_fe = expv; m_fa = c; m_sticky = 1; end
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end else if (m_prev == 15) begin
          m_wp = 1;
          if (m_wrap < 65535) m_wrap++;
        end
      end
      m_prev = c;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all();
    chk("synced", int'(synced), int'(m_synced));
    chk("err_pulse", int'(err_pulse), int'(m_ep));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("err_count", int'(err_count), m_err);
    chk("wrap_pulse", int'(wrap_pulse), int'(m_wp));
    chk("wrap_count", int'(wrap_count), m_wrap);
    chk("first_exp", int'(first_exp), m_fe);
    chk("first_act", int'(first_act), m_fa);
    chk("err_count_sat2", int'(err_count2), m_err2);
    chk("err_pulse_sat2", int'(err_pulse2), int'(m_ep));
  endtask

  // Drive one cycle, let it be captured, then compare #1 after the edge.
  task automatic cyc(input bit r, input bit e, input int c, input bit cl);
    rst = r; en = e; count_in = 4'(c); clr_err = cl;
    @(posedge clk);
    #1;
    model_step(r, e, c, cl);
    check_all();
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 0, 1'b0);
  endtask

  typedef struct {
    bit en; int cin; bit clr;
    bit ep; bit wp; int ecnt; int fe; int fa; bit sticky;
  } vec_t;

  vec_t vecs[6];
  int   npulse;
  int   cur;

  initial begin
    // Early-wrap bug 12,13,14,0,1 with an en gap before the last sample.
    vecs[0] = '{1, 12, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 13, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1, 14, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{1, 0,  0, 1, 0, 1, 15, 0, 1};
    vecs[4] = '{0, 9,  0, 0, 0, 1, 15, 0, 1};
    vecs[5] = '{1, 1,  0, 0, 0, 1, 15, 0, 1};

    rst = 1'b1; en = 1'b0; count_in = '0; clr_err = 1'b0;
    do_reset();
    chk("reset_synced", int'(synced), 0);
    chk("reset_err_count", int'(err_count), 0);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, vecs[i].en, vecs[i].cin, vecs[i].clr);
      chk($sformatf("vec%0d_err_pulse", i), int'(err_pulse), int'(vecs[i].ep));
      chk($sformatf("vec%0d_wrap_pulse", i), int'(wrap_pulse), int'(vecs[i].wp));
      chk($sformatf("vec%0d_err_count", i), int'(err_count), vecs[i].ecnt);
      chk($sformatf("vec%0d_first_exp", i), int'(first_exp), vecs[i].fe);
      chk($sformatf("vec%0d_first_act", i), int'(first_act), vecs[i].fa);
      chk($sformatf("vec%0d_sticky", i), int'(err_sticky), int'(vecs[i].sticky));
    end
    chk("early_wrap_wrap_count", int'(wrap_count), 0);

    // Full sequence 0..15,0,1: one wrap, no errors.
    do_reset();
    npulse = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, 1'b1, i % 16, 1'b0);
      if (wrap_pulse) npulse++;
      chk("full_seq_no_err", int'(err_pulse), 0);
      if (i == 16) chk("full_seq_wrap_at_0", int'(wrap_pulse), 1);
    end
    chk("full_seq_wrap_pulses", npulse, 1);
    chk("full_seq_wrap_count", int'(wrap_count), 1);

    // Gaps in en: 3,4, five idle cycles with 9, then 5.
    do_reset();
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 9, 1'b0);
    cyc(1'b0, 1'b1, 5, 1'b0);
    chk("gap_no_err", int'(err_sticky), 0);

    // Clear with simultaneous error: three errors, then prev=2, then clr + 7.
    do_reset();
    cyc(1'b0, 1'b1, 0, 1'b0);
    cyc(1'b0, 1'b1, 5, 1'b0);
    cyc(1'b0, 1'b1, 9, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    cyc(1'b0, 1'b1, 2, 1'b0);
    chk("clr_pre_err_count", int'(err_count), 3);
    cyc(1'b0, 1'b1, 7, 1'b1);
    chk("clr_same_err_count", int'(err_count), 1);
    chk("clr_same_first_exp", int'(first_exp), 3);
    chk("clr_same_first_act", int'(first_act), 7);
    chk("clr_same_sticky", int'(err_sticky), 1);
    // Plain clear afterwards, then a good sample keeps things clean.
    cyc(1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b1, 8, 1'b0);
    chk("clr_plain_sticky", int'(err_sticky), 0);

    // Saturation: six consecutive mismatches on the 2-bit tally.
    do_reset();
    cyc(1'b0, 1'b1, 0, 1'b0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 5, 1'b0);
      if (err_pulse2) npulse++;
    end
    chk("sat_pulses", npulse, 6);
    chk("sat_err_count2", int'(err_count2), 3);
    chk("sat_err_count8", int'(err_count), 6);

    // Reset mid-run while in FAULT, then 0,1.
    do_reset();
    chk("midrst_synced", int'(synced), 0);
    chk("midrst_sticky", int'(err_sticky), 0);
    chk("midrst_first_act", int'(first_act), 0);
    cyc(1'b0, 1'b1, 0, 1'b0);
    chk("midrst_sync_no_err", int'(err_pulse), 0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    chk("midrst_second_no_err", int'(err_sticky), 0);

    // Randomized traffic against the reference model.
    do_reset();
    cur = 0;
    for (int i = 0; i < 2000; i++) begin
      bit r, e, cl;
      int c;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, 15));
      else c = (cur + 1) % 16;
      if (e) cur = c;
      cyc(r, e, c, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Runtime checker that sits directly downstream of the 4-bit up-counter and consumes its `count` output each sampled cycle. It checks that every sample equals the previous sample plus one, modulo 2^WIDTH (15 wraps to 0). It reports errors, a sticky fault flag, saturating error and wrap tallies, and the expected/actual pair of the first error. It provides the in-silicon counterpart of the formal step property, so counter bugs such as an early wrap at 14 are visible in simulation and on hardware.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `ERR_CNT_W`, 8: width of the error tally (saturating).
- `WRAP_CNT_W`, 16: width of the wrap tally (saturating).

- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: `count_in` is a valid sample this cycle.
- `count_in`  in  WIDTH: counter value under check.
- `clr_err`  in  1: clears error state (sticky flag, error tally, first-error capture).
- `synced`  out  1: a reference sample is held; checking is active.
- `err_pulse`  out  1: one-cycle strobe, mismatch detected.
- `err_sticky`  out  1: at least one mismatch since reset or `clr_err`.
- `err_count`  out  ERR_CNT_W: number of mismatches, saturating at all-ones.
- `wrap_pulse`  out  1: one-cycle strobe, legal MAX→0 wrap seen.
- `wrap_count`  out  WRAP_CNT_W: number of legal wraps, saturating.
- `first_exp`  out  WIDTH: expected value at the first mismatch.
- `first_act`  out  WIDTH: actual value at the first mismatch.

## Operation
- FSM states: IDLE, TRACK, FAULT.
- **IDLE**
  - Entered on reset. No checking takes place.
  - First cycle with `en=1`: load `prev ← count_in`, set `synced`, go to TRACK. No error or wrap is possible on this sample.
- **TRACK / FAULT**
  - On each cycle with `en=1`:
    - Compute `exp = prev + 1`, truncated to WIDTH bits.
    - If `count_in != exp`, it is a mismatch.
    - In all cases, `prev ← count_in`: resync to the actual value, so a single glitch yields exactly one error.
  - Mismatch while `err_sticky=0`:
    - capture `first_exp ← exp`, `first_act ← count_in`;
    - set `err_sticky`;
    - go to FAULT.
  - Any mismatch: pulse `err_pulse`; increment `err_count` with saturation (holds at 2^ERR_CNT_W−1).
  - Legal wrap: `prev == 2^WIDTH−1` and `count_in == 0`. Pulse `wrap_pulse`; increment `wrap_count` with saturation.
  - An early wrap (for example prev=14, in=0) is a mismatch, not a wrap.
- **`en=0`:** no comparison; `prev` and all tallies hold; strobes are 0.
- **`clr_err`** (any state except IDLE):
  - zeroes `err_sticky`, `err_count`, `first_exp`, `first_act`;
  - FAULT → TRACK;
  - `prev`, `synced`, and `wrap_count` are unaffected.
  - In IDLE it has no effect.
- **`clr_err` with a same-cycle mismatch:** the clear applies first, then the new error. Result: `err_count=1`, `err_sticky=1`, first capture = this event, state FAULT.
- `err_pulse` and `wrap_pulse` are mutually exclusive by construction.

## Timing
- All outputs are registered, with a latency of 1 cycle. A sample at edge N appears on the outputs after edge N+1.
- `err_pulse` and `wrap_pulse` are high for exactly one cycle per offending or wrapping sample. Back-to-back events give back-to-back pulses.
- Reset values: state IDLE, `synced=0`, strobes 0, `err_sticky=0`, `err_count=0`, `wrap_count=0`, `first_exp=0`, `first_act=0`, `prev=0`.
- Reset mid-run returns to IDLE. The first sample after reset only re-syncs, so the counter's own reset-to-0 is never flagged.
- `rst` has priority over `clr_err` and `en`.

## Structure
- **Package `count_monitor_pkg`**
  - state typedef `cm_state_t` {IDLE, TRACK, FAULT};
  - default width localparams.
- **Sub-module `sat_counter`**
  - parameterised width; inputs `inc` and `clr`; clr-wins-then-inc semantics.
  - Instantiated twice: error tally and wrap tally.
- Comparator, first-error capture and FSM live in the top module.

## Test plan
- **Full-sequence check:** reset, then `en=1` with count_in 0,1,…,15,0,1.
  - No `err_pulse`.
  - `wrap_pulse` exactly once, one cycle after the 0 following 15.
  - `wrap_count=1`.
- **Early-wrap bug:** sequence 12,13,14,0,1.
  - `err_pulse` once.
  - `first_exp=15`, `first_act=0`, `err_count=1`, `err_sticky=1`.
  - `wrap_count` unchanged.
  - No second error on 1.
- **Gaps in `en`:** sequence 3,4 (en=1), then `en=0` for 5 cycles with count_in=9, then `en=1` with 5.
  - No error; `prev` held at 4.
- **Clear with simultaneous error:** in FAULT with `err_count=3`, assert `clr_err` in the same cycle as sample 7 after prev=2.
  - `err_count=1`, `first_exp=3`, `first_act=7`, state FAULT.
- **Saturation:** ERR_CNT_W=2, feed 6 consecutive mismatches.
  - `err_count` holds at 3.
  - `err_pulse` fires 6 times.
- **Reset mid-run:** `rst` pulse while in FAULT, then samples 0,1.
  - All outputs return to reset values.
  - First sample only syncs; no error.
